i2c_master_tx: RTL and testbench
================================

Name: i2c_master_tx

Overview:
- Write-only I2C master: sends START, 7-bit address + W, then NUM_BYTES data bytes MSB-first, then STOP.
- CPU-side peripheral that drives the board-level LED/FND I2C slaves.
- Uses the fixed bit timing the slaves expect: BIT_CLKS system clocks per bit, with the slave sampling SDA at BIT_CLKS/2 from bit start.

Parameters:
- BIT_CLKS, 1000: system clocks per I2C bit slot (START, data, ACK and STOP slots); must be divisible by 4.
- NUM_BYTES, 2: data bytes per transaction (1..4).

Ports:
- clk  input  1  system clock
- reset  input  1  reset; asynchronous, active-high
- start  input  1  one-cycle request; accepted only in IDLE
- addr  input  7  slave address, latched on accept
- tx_data  input  8*NUM_BYTES  payload, latched on accept; byte [8*NUM_BYTES-1 -: 8] sent first
- busy  output  1  high from the cycle after accept through the last STOP cycle
- done  output  1  one-cycle pulse at end of STOP slot
- ack_err  output  1  status of the last transaction; valid with done, held until next accept
- SCL  output  1  push-pull clock; the slaves only read it
- SDA  inout  1  open-drain: drives 0 or z, never 1

Behaviour:
- Reset values: SCL=1, SDA=z, busy=0, done=0, ack_err=0, state=IDLE, counters=0. Reset mid-transfer releases the bus immediately (asynchronous reset); no STOP is generated.
- Timing: Q=BIT_CLKS/4. Slot counter cnt runs 0..BIT_CLKS-1. Bit counter runs 0..7. Byte counter runs 0..NUM_BYTES-1.
- SDA input is passed through a 2-flop synchroniser (reset value 1) for ACK sampling.
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- IDLE: SCL=1, SDA=z. When start=1, latch the shift register to {addr,1'b0} and latch tx_data. Clear ack_err and all counters. Go to START.
- START (1 slot): SDA=0 for the whole slot. SCL=1 for cnt<2Q, then 0. Slaves detect SDA falling while SCL is high.
- Data bit slot (ADDR, DATA):
  - SCL=0 for cnt<Q, 1 for Q<=cnt<3Q, 0 for cnt>=3Q.
  - SDA = shift MSB (0 -> drive 0, 1 -> z), updated only at cnt==0 while SCL is low.
  - Shift left at cnt==BIT_CLKS-1.
  - After 8 bits, go to the matching _ACK state.
- ACK slot (ADDR_ACK, DATA_ACK):
  - SCL pattern identical to a data bit slot. SDA released (z).
  - Sample synced SDA at cnt==BIT_CLKS/2-1: 0 = ACK.
- ADDR_ACK exit at slot end:
  - NACK: ack_err=1, go to STOP.
  - ACK: load the first data byte, go to DATA.
- DATA_ACK exit at slot end:
  - Non-final byte, NACK: ack_err=1, go to STOP.
  - Non-final byte, ACK: load the next byte, go to DATA.
  - Final byte: go to STOP regardless of the sample. The slave intentionally releases SDA on the final byte, so NACK there is not an error.
- STOP (1 slot): SCL=0 and SDA=0 for cnt<Q; SCL=1 from cnt>=Q; SDA=z from cnt>=2Q. This gives SDA rising 250 clocks after SCL high at default timing, which the slaves require (>50). done=1 at cnt==BIT_CLKS-1; next state IDLE.
- Latency, start accept to done:
  - Full transfer: (1 + 9 + 9*NUM_BYTES + 1)*BIT_CLKS cycles; 29000 at defaults.
  - Address NACK: 11*BIT_CLKS cycles.
- Protocol rules: SDA never changes while SCL=1, except the START falling edge and the STOP rising edge.
- start while busy: ignored; latched data unchanged.
- start in the cycle after done: accepted (state is already IDLE).

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum i2c_master_state_e
  - I2C_WRITE=1'b0 and I2C_READ=1'b1
  - the default BIT_CLKS constant, so master and slaves share timing
- One sub-module, i2c_bit_timer: slot counter, with phase strobes for SDA update (cnt==0), sample (BIT_CLKS/2-1) and slot end (BIT_CLKS-1).
- SCL level is decoded from the count in the master FSM.

Test Plan:
- Bench note: SDA needs a pullup in the bench.
- Full write, matching slave: addr=7'b1100100, tx_data=16'hA55A with the LED slave attached -> serialized bytes 0xC8, 0xA5, 0x5A; done at 29000 cycles after accept; ack_err=0; slave led_data=16'hA55A; slave rx_done pulses once.
- Address mismatch: addr=7'b0000001, no responder -> ADDR_ACK samples 1; STOP follows immediately; done at 11000 cycles; ack_err=1; slave led_data unchanged.
- Data NACK: responder model ACKs the address and NACKs byte 0, NUM_BYTES=2 -> STOP after DATA_ACK of byte 0; done at 20000 cycles; ack_err=1.
- Busy/back-to-back:
  - Pulse start with 16'h1234 during DATA -> ignored; the transaction completes with the original data.
  - Pulse start with 16'h00FF in the cycle after done -> accepted; slave ends with led_data=16'h00FF.
- Reset mid-transfer: assert reset at cycle 5000 (inside ADDR) -> SCL=1, SDA=z, busy=0 at once. After release, a fresh 16'hBEEF write succeeds and the slave recovers via its STOP/IDLE path.
- Protocol monitor over all tests -> no SDA edge while SCL=1 except START fall and STOP rise; STOP SDA rise ≥250 clocks after SCL rise; SCL high time = 2Q per bit.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, R/W bit encodings and the
// default bit timing used by both the master and the board slaves.
package i2c_pkg;

  localparam int unsigned I2C_BIT_CLKS = 1000;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } i2c_master_state_e;

endpackage

// File: rtl/i2c_bit_timer.sv
// Bit-slot counter for the I2C master: counts 0..BIT_CLKS-1 while running
// and flags slot start, the SDA sample point and slot end.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int unsigned BIT_CLKS = I2C_BIT_CLKS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  output logic [$clog2(BIT_CLKS)-1:0] cnt,
  output logic                        upd_stb,
  output logic                        smp_stb,
  output logic                        end_stb
);

  localparam int unsigned CW = $clog2(BIT_CLKS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!run || end_stb)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_comb begin
    upd_stb = (cnt == '0);
    smp_stb = (cnt == CW'(BIT_CLKS / 2 - 1));
    end_stb = (cnt == CW'(BIT_CLKS - 1));
  end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address+W, NUM_BYTES data bytes MSB-first,
// STOP. SDA is open-drain (0 or z); SCL is push-pull.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int unsigned BIT_CLKS  = I2C_BIT_CLKS,
  parameter int unsigned NUM_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             addr,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic                   SCL,
  inout  wire                    SDA
);

  localparam int unsigned CW = $clog2(BIT_CLKS);
  localparam int unsigned TW = 8 * NUM_BYTES;
  localparam logic [CW-1:0] Q1 = CW'(BIT_CLKS / 4);
  localparam logic [CW-1:0] Q2 = CW'(BIT_CLKS / 2);
  localparam logic [CW-1:0] Q3 = CW'(3 * BIT_CLKS / 4);
  localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

  i2c_master_state_e state, state_n;

  logic [CW-1:0] cnt;
  logic          upd_stb, smp_stb, end_stb;
  logic [7:0]    shreg;
  logic [TW-1:0] tx_q;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [1:0]    sda_sync;
  logic          ack_smp;
  logic          last_byte;
  logic          scl, sda_oe;

  i2c_bit_timer #(
    .BIT_CLKS(BIT_CLKS)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state != IDLE),
    .cnt     (cnt),
    .upd_stb (upd_stb),
    .smp_stb (smp_stb),
    .end_stb (end_stb)
  );

  assign last_byte = (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (start) state_n = START;
      START:    if (end_stb) state_n = ADDR;
      ADDR:     if (end_stb && bit_cnt == 3'd7) state_n = ADDR_ACK;
      ADDR_ACK: if (end_stb) state_n = ack_smp ? STOP : DATA;
      DATA:     if (end_stb && bit_cnt == 3'd7) state_n = DATA_ACK;
      // The final byte is NACKed on purpose by the slaves; STOP either way.
      DATA_ACK: if (end_stb) state_n = (last_byte || ack_smp) ? STOP : DATA;
      STOP:     if (end_stb) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    unique case (state)
      IDLE:  busy = 1'b0;
      START: begin
        sda_oe = 1'b1;
        scl    = (cnt < Q2);
      end
      ADDR, DATA: begin
        scl    = (cnt >= Q1) && (cnt < Q3);
        sda_oe = ~shreg[7];
      end
      ADDR_ACK, DATA_ACK: scl = (cnt >= Q1) && (cnt < Q3);
      STOP: begin
        scl    = (cnt >= Q1);
        sda_oe = (cnt < Q2);
        done   = end_stb;
      end
      default: ;
    endcase
  end

  assign SCL = scl;
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      tx_q     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      ack_err  <= 1'b0;
      ack_smp  <= 1'b1;
      sda_sync <= '1;
    end else begin
      sda_sync <= {sda_sync[0], SDA};
      unique case (state)
        IDLE: if (start) begin
          shreg    <= {addr, I2C_WRITE};
          tx_q     <= tx_data;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          ack_err  <= 1'b0;
        end
        ADDR, DATA: if (end_stb) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        ADDR_ACK, DATA_ACK: begin
          // Clear at slot start so a stale ACK can never carry into this slot.
          if (upd_stb)
            ack_smp <= 1'b1;
          else if (smp_stb)
            ack_smp <= sda_sync[1];
          if (end_stb) begin
            if (state == DATA_ACK && last_byte) begin
              // final byte: NACK expected, nothing to load
            end else if (ack_smp) begin
              ack_err <= 1'b1;
            end else begin
              shreg <= tx_q[TW-1 -: 8];
              tx_q  <= tx_q << 8;
              if (state == DATA_ACK)
                byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: LED-slave model plus bus sniffer, scoreboard
// on done, and an SCL/SDA protocol monitor, all sampled on clk falling edges.
module tb_i2c_master_tx;

  localparam int BC = 400;
  localparam int Q  = BC / 4;
  localparam logic [6:0] SLV_ADDR = 7'b1100100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  addr;
  logic [15:0] tx_data;
  logic        busy, done, ack_err, scl;
  wire         sda;

  pullup (sda);

  i2c_master_tx #(
    .BIT_CLKS  (BC),
    .NUM_BYTES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .addr    (addr),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .SCL     (scl),
    .SDA     (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    int          lat;
    logic        err;
    logic [15:0] led;
    int          rx;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_bytes[$];

  int  checks = 0;
  int  errors = 0;
  int  tmo_cnt = 0;
  int  nack_byte = -1;
  bit  mon_en = 1'b0;
  bit  end_req = 1'b0;

  // slave model: ACKs SLV_ADDR+W, ACKs data bytes except nack_byte, releases on the last
  logic        slv_oe = 1'b0;
  assign sda = slv_oe ? 1'b0 : 1'bz;
  logic [15:0] led_data = 16'h0000;
  int          rx_cnt = 0;
  logic [15:0] data_reg = '0;
  logic [7:0]  shift = '0, sn_sh = '0;
  int          bitn = 0, byte_idx = 0, sn_bits = 0;
  bit          listening = 0, matched = 0, in_ack = 0;
  logic        s_scl_p = 1'b1, s_sda_p = 1'b1;

  logic        p_scl = 1'b1, p_sda = 1'b1, p_busy = 1'b0, rst_p = 1'b0;
  bit          rise_busy = 0, stop_in_high = 0;
  int          rise_cyc = 0;
  exp_t        e;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, req, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && !rst_p) begin
      chk("rst_scl", int'(scl), 1);
      chk("rst_sda", int'(sda), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ack_err", int'(ack_err), 0);
    end
    rst_p = reset;

    if (s_scl_p && scl && s_sda_p && !sda) begin
      listening = 1; matched = 0; in_ack = 0; bitn = 0; byte_idx = 0;
      slv_oe = 0; sn_bits = 0;
    end else if (!s_scl_p && scl) begin
      if (listening && !in_ack && bitn < 8) begin
        shift = {shift[6:0], sda};
        bitn++;
      end
      if (sn_bits == 8) sn_bits = 0;
      else begin
        sn_sh = {sn_sh[6:0], sda};
        sn_bits++;
        if (sn_bits == 8) begin
          if (exp_bytes.size() == 0) chk("byte_unexpected", int'(sn_sh), -1);
          else chk("byte", int'(sn_sh), int'(exp_bytes.pop_front()));
        end
      end
    end else if (s_scl_p && !scl && listening) begin
      if (in_ack) begin
        slv_oe = 0; in_ack = 0; bitn = 0;
        if (matched) byte_idx++;
        else listening = 0;
      end else if (bitn == 8) begin
        in_ack = 1;
        if (byte_idx == 0) begin
          matched = (shift == {SLV_ADDR, 1'b0});
          slv_oe  = matched;
        end else begin
          data_reg = {data_reg[7:0], shift};
          if (byte_idx == 2) begin
            led_data = data_reg;
            rx_cnt++;
          end
          slv_oe = (byte_idx < 2) && (byte_idx - 1 != nack_byte);
          if (!slv_oe) matched = 0;
        end
      end
    end
    s_scl_p = scl;
    s_sda_p = sda;

    if (done) begin
      if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("ack_err", int'(ack_err), int'(e.err));
        chk("led_data", int'(led_data), int'(e.led));
        chk("rx_done_count", rx_cnt, e.rx);
      end
    end

    if (!mon_en) begin
      rise_busy = 0;
    end else begin
      if (scl && !p_scl) begin
        rise_cyc = cyc; rise_busy = busy; stop_in_high = 0;
      end
      if (!scl && p_scl && rise_busy && !stop_in_high)
        chk("scl_high_time", cyc - rise_cyc, 2 * Q);
      if (scl && p_scl && sda != p_sda) begin
        if (!sda) chk("sda_fall_scl_high_is_start", int'(p_busy), 0);
        else begin
          stop_in_high = 1;
          chk("stop_sda_rise_gap", int'(busy && (cyc - rise_cyc >= Q) && (cyc - rise_cyc > 50)), 1);
        end
      end
    end
    p_scl = scl; p_sda = sda; p_busy = busy;

    if (end_req) begin
      chk("timeouts", tmo_cnt, 0);
      chk("scoreboard_left", exp_q.size(), 0);
      chk("bytes_left", exp_bytes.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic issue(input logic [6:0] a, input logic [15:0] d, input int slots,
                       input logic err, input logic [15:0] led, input int rx,
                       input int ndata);
    exp_t x;
    @(negedge clk);
    x.acc = cyc + 1; x.lat = slots * BC; x.err = err; x.led = led; x.rx = rx;
    exp_q.push_back(x);
    exp_bytes.push_back({a, 1'b0});
    if (ndata >= 1) exp_bytes.push_back(d[15:8]);
    if (ndata >= 2) exp_bytes.push_back(d[7:0]);
    addr = a; tx_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse(input logic [6:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; tx_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 32 * BC && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) tmo_cnt++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; addr = '0; tx_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    issue(SLV_ADDR, 16'hA55A, 29, 1'b0, 16'hA55A, 1, 2);
    wait_done();
    issue(7'b0000001, 16'h1357, 11, 1'b1, 16'hA55A, 1, 0);
    wait_done();
    nack_byte = 0;
    issue(SLV_ADDR, 16'h6789, 20, 1'b1, 16'hA55A, 1, 1);
    wait_done();
    nack_byte = -1;

    issue(SLV_ADDR, 16'hC33C, 29, 1'b0, 16'hC33C, 2, 2);
    repeat (14 * BC) @(negedge clk);
    pulse(7'b0000001, 16'h1234);
    wait_done();
    issue(SLV_ADDR, 16'h00FF, 29, 1'b0, 16'h00FF, 3, 2);
    wait_done();

    // abort inside the address byte, then a clean transfer
    pulse(SLV_ADDR, 16'hBEEF);
    repeat (5 * BC - 1) @(negedge clk);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    issue(SLV_ADDR, 16'hBEEF, 29, 1'b0, 16'hBEEF, 4, 2);
    wait_done();

    repeat (4) @(negedge clk);
    end_req = 1'b1;
  end

endmodule
